// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: shadow-entry layout and stall-cause encoding.
package hazard_unit_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        DATA = 2'b01,
        LDST = 2'b10,
        MEMW = 2'b11
    } stall_cause_e;

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic             load;
    } hz_entry_t;

endpackage

// File: rtl/hazard_unit_match.sv
// Per-operand hazard matcher: finds the youngest in-flight writer of rs and decides stall or bypass.
// Forwarding is enabled only when HAZARD_UNIT_BYPASS_EN is defined; otherwise every match interlocks.
module hazard_match
    import hazard_unit_pkg::*;
#(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned ALU_RDY  = 1,
    parameter int unsigned LOAD_RDY = 2,
    parameter int unsigned SEL_W    = $clog2(STAGES + 1)
) (
    input  logic [REG_W-1:0]        rs,
    input  logic                    use_rs,
    input  hz_entry_t [STAGES-1:0]  entries,
    output logic                    stall_c,
    output logic [SEL_W-1:0]        sel_c
);

`ifdef HAZARD_UNIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic hit;

    // Scan from EX outward; the first hit is the youngest writer and masks older ones.
    always_comb begin
        stall_c = 1'b0;
        sel_c   = '0;
        hit     = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (!hit && use_rs && (rs != '0) && entries[k].vld && (entries[k].rd == rs)) begin
                hit = 1'b1;
                if (!BYPASS || (entries[k].load ? (k < LOAD_RDY) : (k < ALU_RDY))) begin
                    stall_c = 1'b1;
                end else begin
                    sel_c = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and operand forwarding for the in-order pipeline, driven by a shadow writer pipeline.
// Build option: define HAZARD_UNIT_BYPASS_EN to enable forwarding; undefined gives a pure interlock.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned ALU_RDY  = 1,
    parameter int unsigned LOAD_RDY = 2,
    parameter int unsigned SEL_W    = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             id_load,
    input  logic             id_store,
    input  logic             ex_kill,
    input  logic             mem_wait,
    output logic             id_adv,
    output logic [SEL_W-1:0] a_sel,
    output logic [SEL_W-1:0] b_sel,
    output logic [1:0]       stall_cause,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_entry_t [STAGES-1:0] entries;
    hz_entry_t [STAGES-1:0] entries_nxt;
    logic [CNT_W-1:0]       cnt_nxt;

    logic             stall_a;
    logic             stall_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             ls_hit;
    logic             data_stall;
    logic             ls_stall;
    stall_cause_e     cause;

    hazard_match #(
        .STAGES   (STAGES),
        .ALU_RDY  (ALU_RDY),
        .LOAD_RDY (LOAD_RDY),
        .SEL_W    (SEL_W)
    ) u_match_a (
        .rs      (id_rs1),
        .use_rs  (id_use_a),
        .entries (entries),
        .stall_c (stall_a),
        .sel_c   (sel_a)
    );

    hazard_match #(
        .STAGES   (STAGES),
        .ALU_RDY  (ALU_RDY),
        .LOAD_RDY (LOAD_RDY),
        .SEL_W    (SEL_W)
    ) u_match_b (
        .rs      (id_rs2),
        .use_rs  (id_use_b),
        .entries (entries),
        .stall_c (stall_b),
        .sel_c   (sel_b)
    );

    // A store cannot issue while a load still owns the memory port ahead of it.
    always_comb begin
        ls_hit = 1'b0;
        for (int unsigned k = 0; k < LOAD_RDY; k++) begin
            if (entries[k].load) begin
                ls_hit = 1'b1;
            end
        end
    end

    // Zero-latency advance, select and cause decode from current entries and ID inputs.
    always_comb begin
        data_stall  = id_valid && (stall_a || stall_b);
        ls_stall    = id_valid && id_store && ls_hit;
        id_adv      = !mem_wait && !data_stall && !ls_stall;
        a_sel       = id_valid ? sel_a : '0;
        b_sel       = id_valid ? sel_b : '0;
        cause       = NONE;
        if (mem_wait) begin
            cause = MEMW;
        end else if (data_stall) begin
            cause = DATA;
        end else if (ls_stall) begin
            cause = LDST;
        end
        stall_cause = cause;
    end

    // Shadow pipeline advance: freeze on mem_wait, otherwise shift and inject ID or a bubble.
    always_comb begin
        entries_nxt = entries;
        cnt_nxt     = stall_cnt;
        if (!mem_wait) begin
            for (int unsigned k = 1; k < STAGES; k++) begin
                entries_nxt[k] = entries[k-1];
            end
            entries_nxt[0] = '0;
            if (id_valid && id_adv && !ex_kill) begin
                entries_nxt[0].vld  = id_wr_en && (id_rd != '0);
                entries_nxt[0].rd   = id_rd;
                entries_nxt[0].load = id_load;
            end
        end
        if (!id_adv && (stall_cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries   <= '0;
            stall_cnt <= '0;
        end else begin
            entries   <= entries_nxt;
            stall_cnt <= cnt_nxt;
        end
    end

endmodule
